// File: rtl/rtc_bus_responder_if.sv
// Multiplexed address/data RTC bus between the PicoBlaze controller (master)
// and the RTC responder (slave).
interface rtc_bus_responder_if;
    logic       cs_n;
    logic       ad_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       irq_n;

    modport master (
        output cs_n, ad_n, rd_n, wr_n, data_in,
        input  data_out, data_oe, irq_n
    );

    modport slave (
        input  cs_n, ad_n, rd_n, wr_n, data_in,
        output data_out, data_oe, irq_n
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC bus responder: BCD time/date register file, countdown timer and irq.
// Define RTC_SNAPSHOT_EN to serve 0x21-0x26 reads from a coherent shadow copy.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic                clk,
    input  logic                reset,
    rtc_bus_responder_if.slave  bus
);

    typedef struct packed {
        logic       cs_n;
        logic       ad_n;
        logic       rd_n;
        logic       wr_n;
        logic [7:0] data;
    } bus_sample_t;

    typedef struct packed {
        logic [7:0] sec;
        logic [7:0] min;
        logic [7:0] hour;
        logic [7:0] day;
        logic [7:0] mon;
        logic [7:0] year;
    } time_t;

    localparam bus_sample_t BUS_IDLE = '{cs_n: 1'b1, ad_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, data: 8'h00};
    localparam time_t       TIME_RST = '{sec: 8'h00, min: 8'h00, hour: 8'h00,
                                         day: 8'h01, mon: 8'h01, year: 8'h00};

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h01;
    localparam logic [7:0] ADDR_SEC    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HOUR   = 8'h23;
    localparam logic [7:0] ADDR_DAY    = 8'h24;
    localparam logic [7:0] ADDR_MON    = 8'h25;
    localparam logic [7:0] ADDR_YEAR   = 8'h26;
    localparam logic [7:0] ADDR_TSEC   = 8'h41;
    localparam logic [7:0] ADDR_TMIN   = 8'h42;
    localparam logic [7:0] ADDR_THOUR  = 8'h43;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    // BCD increment returning {carry, value}; anything at or past max wraps to min.
    function automatic logic [8:0] f_bcd_inc(input logic [7:0] v,
                                             input logic [7:0] max_v,
                                             input logic [7:0] min_v);
        if (v >= max_v)
            return {1'b1, min_v};
        else if (v[3:0] >= 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] f_bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] f_month_len(input logic [7:0] mon, input logic leap);
        case (mon)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    bus_sample_t      r_q1;
    bus_sample_t      r_q2;
    logic [7:0]       r_addr;
    logic [CNT_W-1:0] r_presc;
    time_t            r_time;
    logic [7:0]       r_tsec;
    logic [7:0]       r_tmin;
    logic [7:0]       r_thour;
    logic [2:0]       r_ctrl;
    logic             r_flag;
    logic [7:0]       r_data_out;
    logic             r_data_oe;
    logic             r_irq_n;

    logic       w_wr_evt;
    logic       w_addr_wr;
    logic       w_data_wr;
    logic [7:0] w_wdata;
    logic       w_rd_act;
    logic [7:0] w_rdata;
    logic       w_tick;
    logic       w_adv_sec;
    logic       w_adv_min;
    logic       w_adv_hour;
    logic       w_adv_day;
    logic       w_adv_mon;
    logic       w_adv_year;
    logic       w_c_sec;
    logic       w_c_min;
    logic       w_c_hour;
    logic       w_c_day;
    logic       w_c_mon;
    logic       w_c_year;
    logic [7:0] w_sec_inc;
    logic [7:0] w_min_inc;
    logic [7:0] w_hour_inc;
    logic [7:0] w_day_inc;
    logic [7:0] w_mon_inc;
    logic [7:0] w_year_inc;
    logic       w_leap;
    logic [7:0] w_mlen;
    logic       w_tsec_zero;
    logic       w_tmin_zero;
    logic [7:0] w_tsec_dec;
    logic [7:0] w_tmin_dec;
    logic [7:0] w_thour_dec;
    logic       w_tmr_run;
    logic       w_expire;
    logic [2:0] w_ctrl_n;
    logic       w_flag_clr;

    assign bus.data_out = r_data_out;
    assign bus.data_oe  = r_data_oe;
    assign bus.irq_n    = r_irq_n;

    // A write is taken on the wr_n rising edge, using the address/data held while wr_n was low.
    assign w_wr_evt  = ~r_q2.wr_n & r_q1.wr_n & ~r_q2.cs_n;
    assign w_addr_wr = w_wr_evt & ~r_q2.ad_n;
    assign w_data_wr = w_wr_evt &  r_q2.ad_n;
    assign w_wdata   = r_q2.data;
    assign w_rd_act  = ~r_q1.cs_n & r_q1.ad_n & ~r_q1.rd_n & r_q1.wr_n;

    assign w_tick = (r_presc == TICK_LAST);

    assign w_leap = r_time.year[4] ? (r_time.year[3:0] == 4'd2 || r_time.year[3:0] == 4'd6)
                                   : (r_time.year[3:0] == 4'd0 || r_time.year[3:0] == 4'd4 ||
                                      r_time.year[3:0] == 4'd8);
    assign w_mlen = f_month_len(r_time.mon, w_leap);

    assign {w_c_sec,  w_sec_inc}  = f_bcd_inc(r_time.sec,  8'h59, 8'h00);
    assign {w_c_min,  w_min_inc}  = f_bcd_inc(r_time.min,  8'h59, 8'h00);
    assign {w_c_hour, w_hour_inc} = f_bcd_inc(r_time.hour, 8'h23, 8'h00);
    assign {w_c_day,  w_day_inc}  = f_bcd_inc(r_time.day,  w_mlen, 8'h01);
    assign {w_c_mon,  w_mon_inc}  = f_bcd_inc(r_time.mon,  8'h12, 8'h01);
    assign {w_c_year, w_year_inc} = f_bcd_inc(r_time.year, 8'h99, 8'h00);

    assign w_adv_sec  = w_tick & ~r_ctrl[0];
    assign w_adv_min  = w_adv_sec  & w_c_sec;
    assign w_adv_hour = w_adv_min  & w_c_min;
    assign w_adv_day  = w_adv_hour & w_c_hour;
    assign w_adv_mon  = w_adv_day  & w_c_day;
    assign w_adv_year = w_adv_mon  & w_c_mon;

    // Countdown borrows ripple seconds -> minutes -> hours; a non-zero timer never borrows past hours.
    assign w_tsec_zero = (r_tsec == 8'h00);
    assign w_tmin_zero = (r_tmin == 8'h00);
    assign w_tsec_dec  = w_tsec_zero ? 8'h59 : f_bcd_dec(r_tsec);
    assign w_tmin_dec  = !w_tsec_zero ? r_tmin : (w_tmin_zero ? 8'h59 : f_bcd_dec(r_tmin));
    assign w_thour_dec = (w_tsec_zero && w_tmin_zero) ? f_bcd_dec(r_thour) : r_thour;
    assign w_tmr_run   = w_tick & r_ctrl[1] & (|{r_thour, r_tmin, r_tsec});
    assign w_expire    = w_tmr_run & ~(|{w_thour_dec, w_tmin_dec, w_tsec_dec});

    assign w_flag_clr = w_data_wr & (r_addr == ADDR_STATUS) & w_wdata[0];

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_ctrl_n = r_ctrl;
        if (w_data_wr && r_addr == ADDR_CTRL)
            w_ctrl_n = w_wdata[2:0];
        if (w_expire)
            w_ctrl_n[1] = 1'b0;
    end

`ifdef RTC_SNAPSHOT_EN
    time_t r_shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_shadow <= TIME_RST;
        else if (w_addr_wr && w_wdata == ADDR_SEC)
            r_shadow <= r_time;
    end
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (r_addr)
            ADDR_STATUS: w_rdata = {7'd0, r_flag};
            ADDR_CTRL:   w_rdata = {5'd0, r_ctrl};
`ifdef RTC_SNAPSHOT_EN
            ADDR_SEC:    w_rdata = r_shadow.sec;
            ADDR_MIN:    w_rdata = r_shadow.min;
            ADDR_HOUR:   w_rdata = r_shadow.hour;
            ADDR_DAY:    w_rdata = r_shadow.day;
            ADDR_MON:    w_rdata = r_shadow.mon;
            ADDR_YEAR:   w_rdata = r_shadow.year;
`else
            ADDR_SEC:    w_rdata = r_time.sec;
            ADDR_MIN:    w_rdata = r_time.min;
            ADDR_HOUR:   w_rdata = r_time.hour;
            ADDR_DAY:    w_rdata = r_time.day;
            ADDR_MON:    w_rdata = r_time.mon;
            ADDR_YEAR:   w_rdata = r_time.year;
`endif
            ADDR_TSEC:   w_rdata = r_tsec;
            ADDR_TMIN:   w_rdata = r_tmin;
            ADDR_THOUR:  w_rdata = r_thour;
            default:     w_rdata = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q1       <= BUS_IDLE;
            r_q2       <= BUS_IDLE;
            r_addr     <= 8'h00;
            r_presc    <= '0;
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
            r_irq_n    <= 1'b1;
        end else begin
            r_q1       <= '{cs_n: bus.cs_n, ad_n: bus.ad_n, rd_n: bus.rd_n,
                            wr_n: bus.wr_n, data: bus.data_in};
            r_q2       <= r_q1;
            r_presc    <= w_tick ? '0 : r_presc + CNT_W'(1);
            r_data_oe  <= w_rd_act;
            r_data_out <= w_rd_act ? w_rdata : 8'h00;
            r_irq_n    <= ~(r_flag & r_ctrl[2]);
            if (w_addr_wr)
                r_addr <= w_wdata;
        end
    end

    // Host data writes override the tick result for the addressed register only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_time  <= TIME_RST;
            r_tsec  <= 8'h00;
            r_tmin  <= 8'h00;
            r_thour <= 8'h00;
            r_ctrl  <= 3'd0;
            r_flag  <= 1'b0;
        end else begin
            r_time.sec  <= (w_data_wr && r_addr == ADDR_SEC)  ? w_wdata :
                           (w_adv_sec  ? w_sec_inc  : r_time.sec);
            r_time.min  <= (w_data_wr && r_addr == ADDR_MIN)  ? w_wdata :
                           (w_adv_min  ? w_min_inc  : r_time.min);
            r_time.hour <= (w_data_wr && r_addr == ADDR_HOUR) ? w_wdata :
                           (w_adv_hour ? w_hour_inc : r_time.hour);
            r_time.day  <= (w_data_wr && r_addr == ADDR_DAY)  ? w_wdata :
                           (w_adv_day  ? w_day_inc  : r_time.day);
            r_time.mon  <= (w_data_wr && r_addr == ADDR_MON)  ? w_wdata :
                           (w_adv_mon  ? w_mon_inc  : r_time.mon);
            r_time.year <= (w_data_wr && r_addr == ADDR_YEAR) ? w_wdata :
                           (w_adv_year ? w_year_inc : r_time.year);
            r_tsec      <= (w_data_wr && r_addr == ADDR_TSEC)  ? w_wdata :
                           (w_tmr_run ? w_tsec_dec  : r_tsec);
            r_tmin      <= (w_data_wr && r_addr == ADDR_TMIN)  ? w_wdata :
                           (w_tmr_run ? w_tmin_dec  : r_tmin);
            r_thour     <= (w_data_wr && r_addr == ADDR_THOUR) ? w_wdata :
                           (w_tmr_run ? w_thour_dec : r_thour);
            r_ctrl      <= w_ctrl_n;
            r_flag      <= (r_flag & ~w_flag_clr) | w_expire;
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 4-cycle tick; one-tick windows are
// opened by toggling CTRL with two back-to-back 4-cycle data writes.
module tb_rtc_bus_responder;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rtc_bus_responder_if bus_if ();

    rtc_bus_responder #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Four-cycle write strobe; the register update lands a fixed offset after the call starts.
    task automatic bus_cycle(input logic ad, input logic [7:0] d);
        @(negedge clk);
        bus_if.cs_n = 1'b0; bus_if.ad_n = ad; bus_if.data_in = d; bus_if.wr_n = 1'b0;
        @(negedge clk);
        bus_if.wr_n = 1'b1;
        @(negedge clk);
        bus_if.cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic addr_write(input logic [7:0] a);
        bus_cycle(1'b0, a);
    endtask

    task automatic data_write(input logic [7:0] d);
        bus_cycle(1'b1, d);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr_write(a);
        data_write(d);
    endtask

    task automatic read_data(output logic [7:0] v, output logic oe_early, output logic oe_valid);
        @(negedge clk);
        bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b1; bus_if.rd_n = 1'b0;
        @(negedge clk);
        oe_early = bus_if.data_oe;
        @(negedge clk);
        oe_valid = bus_if.data_oe;
        v        = bus_if.data_out;
        bus_if.rd_n = 1'b1; bus_if.cs_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        logic       e, o;
`ifdef RTC_SNAPSHOT_EN
        addr_write(8'h21);
`endif
        addr_write(a);
        read_data(v, e, o);
        check(tag, v, exp);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] mo, input logic [7:0] y);
        bus_write(8'h21, s);
        bus_write(8'h22, m);
        bus_write(8'h23, h);
        bus_write(8'h24, d);
        bus_write(8'h25, mo);
        bus_write(8'h26, y);
    endtask

    // CTRL drops HOLD for exactly four edges, which always contain one tick.
    task automatic tick_once();
        addr_write(8'h01);
        data_write(8'h00);
        data_write(8'h01);
    endtask

    initial begin
        logic [7:0] v;
        logic       e, o;

        reset = 1'b1;
        bus_if.cs_n = 1'b1; bus_if.ad_n = 1'b1; bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
        bus_if.data_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_oe",   {7'd0, bus_if.data_oe}, 8'h00);
        check("rst_irq",  {7'd0, bus_if.irq_n},   8'h01);
        check("rst_dout", bus_if.data_out,        8'h00);

        // Reset in the middle of a read drops the bus at once.
        bus_write(8'h01, 8'h01);
        bus_write(8'h26, 8'h55);
`ifdef RTC_SNAPSHOT_EN
        addr_write(8'h21);
`endif
        addr_write(8'h26);
        @(negedge clk);
        bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b1; bus_if.rd_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrd_oe",   {7'd0, bus_if.data_oe}, 8'h01);
        check("midrd_data", bus_if.data_out,        8'h55);
        #2 reset = 1'b1;
        #1;
        check("midrst_oe",  {7'd0, bus_if.data_oe}, 8'h00);
        check("midrst_irq", {7'd0, bus_if.irq_n},   8'h01);
        @(negedge clk);
        bus_if.cs_n = 1'b1; bus_if.rd_n = 1'b1;
        reset = 1'b0;
        check_reg("rst_day",    8'h24, 8'h01);
        check_reg("rst_month",  8'h25, 8'h01);
        check_reg("rst_year",   8'h26, 8'h00);
        check_reg("rst_ctrl",   8'h01, 8'h00);
        check_reg("rst_status", 8'h00, 8'h00);
        check_reg("rst_tsec",   8'h41, 8'h00);

        // Basic write/read with read latency.
        bus_write(8'h01, 8'h01);
        bus_write(8'h22, 8'h45);
`ifdef RTC_SNAPSHOT_EN
        addr_write(8'h21);
`endif
        addr_write(8'h22);
        read_data(v, e, o);
        check("rd_oe_1clk", {7'd0, e}, 8'h00);
        check("rd_oe_2clk", {7'd0, o}, 8'h01);
        check("rd_min",     v,         8'h45);
        check("rd_oe_done", {7'd0, bus_if.data_oe}, 8'h00);
        check_reg("unmapped", 8'h30, 8'h00);

        // Leap-year February.
        set_time(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 8'h24);
        tick_once();
        check_reg("leap_sec",   8'h21, 8'h00);
        check_reg("leap_min",   8'h22, 8'h00);
        check_reg("leap_hour",  8'h23, 8'h00);
        check_reg("leap_day",   8'h24, 8'h29);
        check_reg("leap_month", 8'h25, 8'h02);
        bus_write(8'h21, 8'h59);
        bus_write(8'h22, 8'h59);
        bus_write(8'h23, 8'h23);
        tick_once();
        check_reg("leap_day2",   8'h24, 8'h01);
        check_reg("leap_month2", 8'h25, 8'h03);

        // Non-leap February.
        set_time(8'h23, 8'h59, 8'h59, 8'h28, 8'h02, 8'h23);
        tick_once();
        check_reg("nleap_day",   8'h24, 8'h01);
        check_reg("nleap_month", 8'h25, 8'h03);

        // 30-day month and New Year rollover.
        set_time(8'h23, 8'h59, 8'h59, 8'h30, 8'h04, 8'h23);
        tick_once();
        check_reg("apr_day",   8'h24, 8'h01);
        check_reg("apr_month", 8'h25, 8'h05);
        set_time(8'h23, 8'h59, 8'h59, 8'h31, 8'h12, 8'h99);
        tick_once();
        check_reg("ny_day",   8'h24, 8'h01);
        check_reg("ny_month", 8'h25, 8'h01);
        check_reg("ny_year",  8'h26, 8'h00);
        check_reg("ny_hour",  8'h23, 8'h00);

        // Out-of-range seconds wrap as if at 0x59.
        set_time(8'h10, 8'h20, 8'h5A, 8'h05, 8'h06, 8'h07);
        tick_once();
        check_reg("oor_sec", 8'h21, 8'h00);
        check_reg("oor_min", 8'h22, 8'h21);

        // Timer borrow across all three fields: 01:00:00 -> 00:59:59.
        bus_write(8'h43, 8'h01);
        bus_write(8'h42, 8'h00);
        bus_write(8'h41, 8'h00);
        addr_write(8'h01);
        data_write(8'h03);
        data_write(8'h01);
        check_reg("tdec_hour", 8'h43, 8'h00);
        check_reg("tdec_min",  8'h42, 8'h59);
        check_reg("tdec_sec",  8'h41, 8'h59);

        // Timer expiry, irq and write-1-to-clear.
        bus_write(8'h41, 8'h02);
        bus_write(8'h42, 8'h00);
        bus_write(8'h43, 8'h00);
        bus_write(8'h01, 8'h06);
        repeat (20) @(negedge clk);
        check("exp_irq", {7'd0, bus_if.irq_n}, 8'h00);
        check_reg("exp_status", 8'h00, 8'h01);
        check_reg("exp_ctrl",   8'h01, 8'h04);
        check_reg("exp_tsec",   8'h41, 8'h00);
        addr_write(8'h00);
        data_write(8'h01);
        check("w1c_irq_hold", {7'd0, bus_if.irq_n}, 8'h00);
        @(negedge clk);
        check("w1c_irq_rel",  {7'd0, bus_if.irq_n}, 8'h01);
        check_reg("w1c_status", 8'h00, 8'h00);

        // Simultaneous rd_n/wr_n: write wins, bus never driven.
        bus_write(8'h01, 8'h01);
        addr_write(8'h21);
        @(negedge clk);
        bus_if.cs_n = 1'b0; bus_if.ad_n = 1'b1; bus_if.data_in = 8'h37;
        bus_if.rd_n = 1'b0; bus_if.wr_n = 1'b0;
        @(negedge clk);
        check("rw_oe_a", {7'd0, bus_if.data_oe}, 8'h00);
        bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
        @(negedge clk);
        check("rw_oe_b", {7'd0, bus_if.data_oe}, 8'h00);
        bus_if.cs_n = 1'b1;
        @(negedge clk);
        check("rw_oe_c", {7'd0, bus_if.data_oe}, 8'h00);
        check_reg("rw_sec", 8'h21, 8'h37);

`ifdef RTC_SNAPSHOT_EN
        // A tick between reads of 0x21 and 0x22 leaves the shadowed minutes unchanged.
        bus_write(8'h21, 8'h59);
        bus_write(8'h22, 8'h10);
        addr_write(8'h21);
        read_data(v, e, o);
        check("snap_sec", v, 8'h59);
        tick_once();
        addr_write(8'h22);
        read_data(v, e, o);
        check("snap_min", v, 8'h10);
        check_reg("live_min", 8'h22, 8'h11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
